p4_mem_stage: RTL and testbench

P4 memory-access stage of the 5-stage RV32I pipeline. It takes execute-stage (P3) results and issues data-memory loads and stores over a req/gnt + rvalid bus. It aligns, extends and byte-enables the data, and produces the fields loaded into the P4→P5 pipeline register (reg write data, ctrl, insn). It stalls upstream stages while a memory transaction is outstanding and inserts bubbles (o_valid=0) downstream.

---
 rtl/p4_mem_stage_if.sv | 26 ++
 rtl/p4_mem_stage.sv | 238 +++++++++++++++++++++++
 tb/tb_p4_mem_stage.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/p4_mem_stage_if.sv
// -----------------------------------------------------------------------------
// p4_mem_stage_if
// Data-memory bus between the P4 memory stage (master) and data memory (slave).
// The request phase uses req/gnt. Load data comes back later on rvalid/rdata.
//   req    : request valid (master -> slave)
//   gnt    : request accepted this cycle (slave -> master)
//   we     : 1 = store, 0 = load
//   addr   : word-aligned byte address
//   be     : byte enables
//   wdata  : lane-shifted store data
//   rvalid : load data valid (slave -> master)
//   rdata  : load data word (slave -> master)
// -----------------------------------------------------------------------------
interface p4_mem_stage_if;
  logic        req;
  logic        gnt;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/p4_mem_stage.sv
// -----------------------------------------------------------------------------
// p4_mem_stage
// P4 memory-access stage of the 5-stage RV32I pipeline. Non-memory results pass
// straight through. Loads and stores go out on the dmem bus. The stage stalls
// upstream while a transaction is outstanding and sends bubbles downstream.
//
// Optional macro P4_MISALIGN_TRAP_EN: when defined, a misaligned access makes
// no bus request. It retires in one cycle with o_misalign=1 and o_reg_wr=0.
// When undefined, o_misalign is 0 and the low address bits that do not apply
// to the access size are ignored.
//
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_valid .. i_insn   P3 result: ALU result or address, store data, funct3,
//                       mem rd/wr, reg write enable, rd, instruction word
//   o_stall             hold P3 and earlier stages this cycle
//   dmem                data-memory bus (master side)
//   o_valid .. o_insn   fields loaded into the P4/P5 pipeline register
//   o_misalign          misaligned-access flag
// -----------------------------------------------------------------------------
module p4_mem_stage #(
  parameter logic [31:0] NOP_INSN = 32'h00000013
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  input  logic [31:0]           i_alu_result,
  input  logic [31:0]           i_store_data,
  input  logic [2:0]            i_funct3,
  input  logic                  i_mem_rd,
  input  logic                  i_mem_wr,
  input  logic                  i_reg_wr,
  input  logic [4:0]            i_rd,
  input  logic [31:0]           i_insn,
  output logic                  o_stall,
  p4_mem_stage_if.master        dmem,
  output logic                  o_valid,
  output logic                  o_reg_wr,
  output logic [4:0]            o_rd,
  output logic [31:0]           o_reg_wr_data,
  output logic [31:0]           o_insn,
  output logic                  o_misalign
);

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

  // Stores use only 000/001 as sub-word sizes. Loads also have the unsigned
  // forms 100/101. Every other code is treated as a word.
  function automatic size_t acc_size(input logic [2:0] f3, input logic we);
    size_t sz;
    sz = SZ_WORD;
    if (we) begin
      if (f3 == 3'b000)      sz = SZ_BYTE;
      else if (f3 == 3'b001) sz = SZ_HALF;
    end else begin
      if (f3[1:0] == 2'b00 && !(f3 == 3'b000 || f3 == 3'b100)) sz = SZ_WORD;
      else if (f3 == 3'b000 || f3 == 3'b100) sz = SZ_BYTE;
      else if (f3 == 3'b001 || f3 == 3'b101) sz = SZ_HALF;
    end
    return sz;
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] rdata,
                                           input logic [2:0] f3,
                                           input logic [1:0] off);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] res;
    case (off)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    // Halfword lane is picked by addr[1] alone, so addr[0] is ignored here.
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      3'b000:  res = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  res = {24'h0, byte_sel};
      3'b001:  res = {{16{half_sel[15]}}, half_sel};
      3'b101:  res = {16'h0, half_sel};
      default: res = rdata;
    endcase
    return res;
  endfunction

  state_t      state, state_nxt;
  logic [31:0] lat_addr, lat_wdata, lat_insn;
  logic [3:0]  lat_be;
  logic        lat_we, lat_reg_wr;
  logic [2:0]  lat_funct3;
  logic [4:0]  lat_rd;

  // Bus fields derived directly from the P3 inputs (used in IDLE and latched)
  logic        is_mem, is_store, in_misalign, trap, latch_en;
  size_t       in_size;
  logic [1:0]  in_off;
  logic [3:0]  in_be;
  logic [31:0] in_wdata;

  always_comb begin
    is_mem   = i_mem_rd | i_mem_wr;
    is_store = i_mem_wr;
    in_off   = i_alu_result[1:0];
    in_size  = acc_size(i_funct3, is_store);
    case (in_size)
      SZ_BYTE: begin
        in_be    = 4'b0001 << in_off;
        in_wdata = {4{i_store_data[7:0]}};
      end
      SZ_HALF: begin
        in_be    = 4'b0011 << {in_off[1], 1'b0};
        in_wdata = {2{i_store_data[15:0]}};
      end
      default: begin
        in_be    = 4'hF;
        in_wdata = i_store_data;
      end
    endcase
    in_misalign = ((in_size == SZ_HALF) && in_off[0]) ||
                  ((in_size == SZ_WORD) && (in_off != 2'b00));
  end

`ifdef P4_MISALIGN_TRAP_EN
  assign trap = i_valid && is_mem && in_misalign;
`else
  assign trap = 1'b0;
`endif

  // NOTE: each always_comb output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt     = state;
    latch_en      = 1'b0;
    o_stall       = 1'b0;
    o_valid       = 1'b0;
    o_reg_wr      = 1'b0;
    o_rd          = 5'd0;
    o_reg_wr_data = 32'h0;
    o_insn        = NOP_INSN;
    o_misalign    = 1'b0;
    dmem.req      = 1'b0;
    dmem.we       = lat_we;
    dmem.addr     = {lat_addr[31:2], 2'b00};
    dmem.be       = lat_be;
    dmem.wdata    = lat_wdata;

    case (state)
      IDLE: begin
        dmem.we    = is_store;
        dmem.addr  = {i_alu_result[31:2], 2'b00};
        dmem.be    = in_be;
        dmem.wdata = in_wdata;
        if (i_valid && (!is_mem || trap)) begin
          o_valid       = 1'b1;
          o_reg_wr      = i_reg_wr && !trap;
          o_rd          = i_rd;
          o_reg_wr_data = i_alu_result;
          o_insn        = i_insn;
          o_misalign    = trap;
        end else if (i_valid) begin
          dmem.req = 1'b1;
          if (dmem.gnt && is_store) begin
            o_valid       = 1'b1;
            o_reg_wr      = i_reg_wr;
            o_rd          = i_rd;
            o_reg_wr_data = i_alu_result;
            o_insn        = i_insn;
          end else begin
            latch_en  = 1'b1;
            o_stall   = 1'b1;
            state_nxt = dmem.gnt ? RSP : REQ;
          end
        end
      end
      REQ: begin
        dmem.req = 1'b1;
        o_stall  = 1'b1;
        if (dmem.gnt) begin
          if (lat_we) begin
            o_stall       = 1'b0;
            o_valid       = 1'b1;
            o_reg_wr      = lat_reg_wr;
            o_rd          = lat_rd;
            o_reg_wr_data = lat_addr;
            o_insn        = lat_insn;
            state_nxt     = IDLE;
          end else begin
            state_nxt = RSP;
          end
        end
      end
      RSP: begin
        o_stall = 1'b1;
        if (dmem.rvalid) begin
          o_stall       = 1'b0;
          o_valid       = 1'b1;
          o_reg_wr      = lat_reg_wr;
          o_rd          = lat_rd;
          o_reg_wr_data = load_ext(dmem.rdata, lat_funct3, lat_addr[1:0]);
          o_insn        = lat_insn;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples values from before the clock edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      lat_addr   <= 32'h0;
      lat_wdata  <= 32'h0;
      lat_be     <= 4'h0;
      lat_we     <= 1'b0;
      lat_funct3 <= 3'h0;
      lat_reg_wr <= 1'b0;
      lat_rd     <= 5'd0;
      lat_insn   <= NOP_INSN;
    end else begin
      state <= state_nxt;
      if (latch_en) begin
        lat_addr   <= i_alu_result;
        lat_wdata  <= in_wdata;
        lat_be     <= in_be;
        lat_we     <= is_store;
        lat_funct3 <= i_funct3;
        lat_reg_wr <= i_reg_wr;
        lat_rd     <= i_rd;
        lat_insn   <= i_insn;
      end
    end
  end

endmodule

// File: tb/tb_p4_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_p4_mem_stage
// Directed bench for p4_mem_stage. Inputs change on the falling edge. Outputs
// are sampled 1 ns later, well away from the rising edge. Expected values are
// worked out by hand for each step.
// -----------------------------------------------------------------------------
module tb_p4_mem_stage;
  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid;
  logic [31:0] i_alu_result, i_store_data, i_insn;
  logic [2:0]  i_funct3;
  logic        i_mem_rd, i_mem_wr, i_reg_wr;
  logic [4:0]  i_rd;
  logic        o_stall, o_valid, o_reg_wr, o_misalign;
  logic [4:0]  o_rd;
  logic [31:0] o_reg_wr_data, o_insn;

  int n_cmp = 0;
  int n_bad = 0;

  p4_mem_stage_if dmem ();

  p4_mem_stage dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_valid      (i_valid),
    .i_alu_result (i_alu_result),
    .i_store_data (i_store_data),
    .i_funct3     (i_funct3),
    .i_mem_rd     (i_mem_rd),
    .i_mem_wr     (i_mem_wr),
    .i_reg_wr     (i_reg_wr),
    .i_rd         (i_rd),
    .i_insn       (i_insn),
    .o_stall      (o_stall),
    .dmem         (dmem.master),
    .o_valid      (o_valid),
    .o_reg_wr     (o_reg_wr),
    .o_rd         (o_rd),
    .o_reg_wr_data(o_reg_wr_data),
    .o_insn       (o_insn),
    .o_misalign   (o_misalign)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] sd,
                       input logic [2:0] f3, input logic rd_en, input logic wr_en,
                       input logic rw, input logic [4:0] rd, input logic [31:0] insn);
    i_valid = v; i_alu_result = alu; i_store_data = sd; i_funct3 = f3;
    i_mem_rd = rd_en; i_mem_wr = wr_en; i_reg_wr = rw; i_rd = rd; i_insn = insn;
  endtask

  task automatic step();
    @(negedge i_clk);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    i_rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    dmem.gnt = 0; dmem.rvalid = 0; dmem.rdata = 0;
    settle();
    check("rst_req",   dmem.req, 0);
    check("rst_stall", o_stall, 0);
    check("rst_valid", o_valid, 0);
    check("rst_insn",  o_insn, 32'h00000013);
    step(); step();
    i_rst_n = 1'b1;

    // ADD pass-through
    step();
    drive(1, 32'h1234, 0, 3'b000, 0, 0, 1, 5'd5, 32'h00B50533);
    settle();
    check("add_valid", o_valid, 1);
    check("add_data",  o_reg_wr_data, 32'h1234);
    check("add_stall", o_stall, 0);
    check("add_req",   dmem.req, 0);
    check("add_rd",    o_rd, 5);
    check("add_insn",  o_insn, 32'h00B50533);

    // SB 0x1003, gnt held low for two cycles
    step();
    drive(1, 32'h1003, 32'h123456AB, 3'b000, 0, 1, 0, 5'd0, 32'h00A581A3);
    for (int c = 0; c < 3; c++) begin
      if (c > 0) begin
        step();
        i_alu_result = 32'hDEAD_BEE0;  // latched copy must be used
        i_store_data = 32'h0;
      end
      dmem.gnt = (c == 2);
      settle();
      check("sb_req",   dmem.req, 1);
      check("sb_we",    dmem.we, 1);
      check("sb_addr",  dmem.addr, 32'h1000);
      check("sb_be",    dmem.be, 4'b1000);
      check("sb_wdata", dmem.wdata, 32'hABABABAB);
      check("sb_stall", o_stall, (c == 2) ? 0 : 1);
      check("sb_valid", o_valid, (c == 2) ? 1 : 0);
    end
    check("sb_insn", o_insn, 32'h00A581A3);

    // LB 0x2001, immediate gnt, rvalid three cycles later
    step();
    dmem.gnt = 1;
    drive(1, 32'h2001, 0, 3'b000, 1, 0, 1, 5'd7, 32'h00100383);
    settle();
    check("lb_req",   dmem.req, 1);
    check("lb_we",    dmem.we, 0);
    check("lb_addr",  dmem.addr, 32'h2000);
    check("lb_be",    dmem.be, 4'b0010);
    check("lb_stall", o_stall, 1);
    check("lb_valid", o_valid, 0);
    step(); dmem.gnt = 0; i_alu_result = 32'h0;
    settle();
    check("lb_wait_req",   dmem.req, 0);
    check("lb_wait_stall", o_stall, 1);
    step(); settle();
    check("lb_wait2_stall", o_stall, 1);
    check("lb_wait2_valid", o_valid, 0);
    step(); dmem.rvalid = 1; dmem.rdata = 32'h00008000;
    settle();
    check("lb_data",  o_reg_wr_data, 32'hFFFFFF80);
    check("lb_valid", o_valid, 1);
    check("lb_stall_done", o_stall, 0);
    check("lb_rd",    o_rd, 7);
    check("lb_regwr", o_reg_wr, 1);

    // LBU 0x2001, same data
    step(); dmem.rvalid = 0; dmem.gnt = 1;
    drive(1, 32'h2001, 0, 3'b100, 1, 0, 1, 5'd8, 32'h00104403);
    settle();
    check("lbu_stall", o_stall, 1);
    step(); dmem.gnt = 0; dmem.rvalid = 1; dmem.rdata = 32'h00008000;
    settle();
    check("lbu_data", o_reg_wr_data, 32'h00000080);

    // LHU 0x2002
    step(); dmem.rvalid = 0; dmem.gnt = 1;
    drive(1, 32'h2002, 0, 3'b101, 1, 0, 1, 5'd9, 32'h00205483);
    settle();
    check("lhu_be", dmem.be, 4'b1100);
    step(); dmem.gnt = 0; dmem.rvalid = 1; dmem.rdata = 32'hBEEF1234;
    settle();
    check("lhu_data", o_reg_wr_data, 32'h0000BEEF);

    // LH 0x2000, negative low half
    step(); dmem.rvalid = 0; dmem.gnt = 1;
    drive(1, 32'h2000, 0, 3'b001, 1, 0, 1, 5'd10, 32'h00001503);
    step(); dmem.gnt = 0; dmem.rvalid = 1; dmem.rdata = 32'h1234_8001;
    settle();
    check("lh_data", o_reg_wr_data, 32'hFFFF8001);

    // LW 0x2000
    step(); dmem.rvalid = 0; dmem.gnt = 1;
    drive(1, 32'h2000, 0, 3'b010, 1, 0, 1, 5'd11, 32'h00002583);
    settle();
    check("lw_be", dmem.be, 4'hF);
    step(); dmem.gnt = 0; dmem.rvalid = 1; dmem.rdata = 32'hBEEF1234;
    settle();
    check("lw_data", o_reg_wr_data, 32'hBEEF1234);

    // SH 0x2002 with immediate gnt: completes in the same cycle
    step(); dmem.rvalid = 0; dmem.gnt = 1;
    drive(1, 32'h2002, 32'hCAFE5678, 3'b001, 0, 1, 0, 5'd0, 32'h00B11123);
    settle();
    check("sh_be",    dmem.be, 4'b1100);
    check("sh_wdata", dmem.wdata, 32'h56785678);
    check("sh_valid", o_valid, 1);
    check("sh_stall", o_stall, 0);

    // Reset while waiting in RSP, then a stale rvalid
    step();
    drive(1, 32'h4000, 0, 3'b010, 1, 0, 1, 5'd12, 32'h00002603);
    settle();
    check("rsp_pre_stall", o_stall, 1);
    step(); dmem.gnt = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    i_rst_n = 1'b0;
    settle();
    check("rstmid_stall", o_stall, 0);
    check("rstmid_valid", o_valid, 0);
    check("rstmid_insn",  o_insn, 32'h00000013);
    step(); i_rst_n = 1'b1; dmem.rvalid = 1; dmem.rdata = 32'h55555555;
    settle();
    check("stale_valid", o_valid, 0);
    check("stale_insn",  o_insn, 32'h00000013);
    check("stale_stall", o_stall, 0);
    check("stale_req",   dmem.req, 0);
    step(); dmem.rvalid = 0;

    // Misaligned LW 0x3002
    step(); dmem.gnt = 1;
    drive(1, 32'h3002, 0, 3'b010, 1, 0, 1, 5'd13, 32'h00002683);
    settle();
`ifdef P4_MISALIGN_TRAP_EN
    check("mis_req",    dmem.req, 0);
    check("mis_flag",   o_misalign, 1);
    check("mis_regwr",  o_reg_wr, 0);
    check("mis_valid",  o_valid, 1);
    check("mis_stall",  o_stall, 0);
    step(); dmem.gnt = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    check("mis_flag_clr", o_misalign, 0);
    check("mis_valid_clr", o_valid, 0);
`else
    check("mis_req",   dmem.req, 1);
    check("mis_addr",  dmem.addr, 32'h3000);
    check("mis_be",    dmem.be, 4'hF);
    check("mis_flag",  o_misalign, 0);
    step(); dmem.gnt = 0; dmem.rvalid = 1; dmem.rdata = 32'h11223344;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    check("mis_data",  o_reg_wr_data, 32'h11223344);
    check("mis_valid", o_valid, 1);
    check("mis_rd",    o_rd, 13);
    step(); dmem.rvalid = 0;
`endif

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
